// File: rtl/cnn_window_feeder.sv
// Input staging for the CNN datapath: captures one 75-word pattern and streams the
// 108 padded 2x2 windows (3 channels x 6x6 positions) as soon as their pixels exist.
module cnn_window_feeder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [31:0]  Img,
  input  logic [31:0]  Kernel_ch1,
  input  logic [31:0]  Kernel_ch2,
  input  logic [31:0]  Weight,
  input  logic         Opt,
  output logic         win_valid,
  output logic [31:0]  win_p0,
  output logic [31:0]  win_p1,
  output logic [31:0]  win_p2,
  output logic [31:0]  win_p3,
  output logic [1:0]   win_ch,
  output logic [2:0]   win_row,
  output logic [2:0]   win_col,
  output logic         win_last,
  output logic [383:0] ker1_q,
  output logic [383:0] ker2_q,
  output logic [767:0] wgt_q,
  output logic         opt_q
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic [31:0]   img_q [75];
  logic          img_we;
  logic [6:0]    wr_idx;
  logic [383:0]  ker1_d, ker2_d;
  logic [767:0]  wgt_d;
  logic          opt_d;
  logic          win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic [1:0]    win_ch_q, win_ch_d;
  logic [2:0]    win_row_q, win_row_d, win_col_q, win_col_d;
  logic [31:0]   win_p_q [4];
  logic [31:0]   win_p_d [4];
  logic [31:0]   tap [4];
  logic [6:0]    need;
  logic          is_last;

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win_ch    = win_ch_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_p0    = win_p_q[0];
  assign win_p1    = win_p_q[1];
  assign win_p2    = win_p_q[2];
  assign win_p3    = win_p_q[3];

  // Highest image index touched by the current window; it must already be stored.
  always_comb begin
    need = 7'(ch_q) * 7'd25 + ((row_q > 3'd4) ? 7'd4 : 7'(row_q)) * 7'd5
         + ((col_q > 3'd4) ? 7'd4 : 7'(col_q));
  end

  assign is_last = (ch_q == 2'd2) && (row_q == 3'd5) && (col_q == 3'd5);

  // Padded coordinate p maps to image p-1; the border rows/cols are 0 and 6.
  always_comb begin
    logic [2:0] pr, pc, ir, ic;
    for (int t = 0; t < 4; t++) begin
      pr = row_q + 3'(t / 2);
      pc = col_q + 3'(t % 2);
      ir = (pr == 3'd0) ? 3'd0 : (pr == 3'd6) ? 3'd4 : pr - 3'd1;
      ic = (pc == 3'd0) ? 3'd0 : (pc == 3'd6) ? 3'd4 : pc - 3'd1;
      tap[t] = img_q[7'(ch_q) * 7'd25 + 7'(ir) * 7'd5 + 7'(ic)];
      if (opt_q && (pr == 3'd0 || pr == 3'd6 || pc == 3'd0 || pc == 3'd6)) tap[t] = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    row_d       = row_q;
    col_d       = col_q;
    ker1_d      = ker1_q;
    ker2_d      = ker2_q;
    wgt_d       = wgt_q;
    opt_d       = opt_q;
    img_we      = 1'b0;
    wr_idx      = cnt_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    win_ch_d    = '0;
    win_row_d   = '0;
    win_col_d   = '0;
    for (int t = 0; t < 4; t++) win_p_d[t] = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          cnt_d   = 7'd1;
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          opt_d   = Opt;
          img_we  = 1'b1;
          wr_idx  = '0;
        end
      end
      StRun: begin
        if (in_valid && cnt_q < 7'd75) begin
          img_we = 1'b1;
          cnt_d  = cnt_q + 7'd1;
        end
        if (win_last_q) begin
          state_d = StIdle;
        end else if (cnt_q > need) begin
          win_valid_d = 1'b1;
          win_last_d  = is_last;
          win_ch_d    = ch_q;
          win_row_d   = row_q;
          win_col_d   = col_q;
          win_p_d     = tap;
          if (!is_last) begin
            if (col_q == 3'd5) begin
              col_d = '0;
              if (row_q == 3'd5) begin
                row_d = '0;
                ch_d  = ch_q + 2'd1;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (img_we) begin
      if (wr_idx < 7'd12) begin
        ker1_d[{wr_idx, 5'd0} +: 32] = Kernel_ch1;
        ker2_d[{wr_idx, 5'd0} +: 32] = Kernel_ch2;
      end
      if (wr_idx < 7'd24) wgt_d[{wr_idx, 5'd0} +: 32] = Weight;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ker1_q      <= '0;
      ker2_q      <= '0;
      wgt_q       <= '0;
      opt_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_ch_q    <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int t = 0; t < 4; t++) win_p_q[t] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ker1_q      <= ker1_d;
      ker2_q      <= ker2_d;
      wgt_q       <= wgt_d;
      opt_q       <= opt_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_ch_q    <= win_ch_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      for (int t = 0; t < 4; t++) win_p_q[t] <= win_p_d[t];
    end
  end

  // Pixel storage needs no reset: a window is only read after its pixels are written.
  always_ff @(posedge clk) begin
    if (img_we) img_q[wr_idx] <= Img;
  end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Scoreboard bench for cnn_window_feeder: expected windows are queued when a pattern
// is driven and popped as the DUT emits them; scenario tasks add targeted checks.
module tb_cnn_window_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  Img = '0, Kernel_ch1 = '0, Kernel_ch2 = '0, Weight = '0;
  logic         Opt = 1'b0;
  logic         win_valid, win_last, opt_q;
  logic [31:0]  win_p0, win_p1, win_p2, win_p3;
  logic [1:0]   win_ch;
  logic [2:0]   win_row, win_col;
  logic [383:0] ker1_q, ker2_q;
  logic [767:0] wgt_q;

  cnn_window_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .Img        (Img),
    .Kernel_ch1 (Kernel_ch1),
    .Kernel_ch2 (Kernel_ch2),
    .Weight     (Weight),
    .Opt        (Opt),
    .win_valid  (win_valid),
    .win_p0     (win_p0),
    .win_p1     (win_p1),
    .win_p2     (win_p2),
    .win_p3     (win_p3),
    .win_ch     (win_ch),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_last   (win_last),
    .ker1_q     (ker1_q),
    .ker2_q     (ker2_q),
    .wgt_q      (wgt_q),
    .opt_q      (opt_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
    logic [31:0] p0, p1, p2, p3;
  } win_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0 = 0;
  int   w41_edge = 0;
  int   obs_n = 0;
  win_t exp_q[$];
  win_t obs_win [108];
  int   obs_cyc [108];

  always @(posedge clk) cyc <= cyc + 1;

  // Small integer to binary32, exact for 0..255.
  function automatic logic [31:0] int2f(input int k);
    int e = 0;
    if (k == 0) return 32'h0;
    for (int b = 0; b < 8; b++) if (((k >> b) & 1) == 1) e = b;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h7f_ffff)};
  endfunction

  function automatic logic [31:0] model_pix(input int ch, input int pr, input int pc,
                                            input bit zp);
    int r = pr - 1;
    int c = pc - 1;
    if (r < 0 || r > 4 || c < 0 || c > 4) begin
      if (zp) return 32'h0;
      if (r < 0) r = 0;
      if (r > 4) r = 4;
      if (c < 0) c = 0;
      if (c > 4) c = 4;
    end
    return int2f(25 * ch + 5 * r + c);
  endfunction

  task automatic push_expected(input bit zp);
    win_t e;
    for (int w = 0; w < 108; w++) begin
      e.ch   = 2'(w / 36);
      e.row  = 3'((w % 36) / 6);
      e.col  = 3'(w % 6);
      e.last = (w == 107);
      e.p0   = model_pix(w / 36, (w % 36) / 6,     w % 6,     zp);
      e.p1   = model_pix(w / 36, (w % 36) / 6,     w % 6 + 1, zp);
      e.p2   = model_pix(w / 36, (w % 36) / 6 + 1, w % 6,     zp);
      e.p3   = model_pix(w / 36, (w % 36) / 6 + 1, w % 6 + 1, zp);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    win_t got;
    win_t e;
    if (win_valid) begin
      got = {win_ch, win_row, win_col, win_last, win_p0, win_p1, win_p2, win_p3};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got %h required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL window_%0d got %h required %h", obs_n, got, e);
        end
      end
      if (obs_n < 108) begin
        obs_win[obs_n] = got;
        obs_cyc[obs_n] = cyc;
      end
      obs_n++;
    end else begin
      checks++;
      if ({win_last, win_ch, win_row, win_col, win_p0, win_p1, win_p2, win_p3} !== '0) begin
        errors++;
        $display("FAIL idle_outputs_zero got %b/%h/%h", win_last, win_p0, win_p3);
      end
    end
  end

  // Drives one pattern; stops before word stop_at, inserts gap_len idle cycles before gap_at.
  task automatic drive_pattern(input bit zp, input int kbase, input int gap_at,
                               input int gap_len, input int stop_at);
    push_expected(zp);
    obs_n = 0;
    for (int k = 0; k < 75; k++) begin
      if (k == stop_at) return;
      if (k == gap_at) begin
        repeat (gap_len) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (k == 0) e0 = cyc + 1;
      if (k == 41) w41_edge = cyc + 1;
      in_valid   = 1'b1;
      Img        = int2f(k);
      Opt        = (k == 0) ? zp : ~zp;
      Kernel_ch1 = (k < 12) ? 32'(kbase + k) : 32'hdead_beef;
      Kernel_ch2 = (k < 12) ? 32'(200 + kbase + k) : 32'hdead_beef;
      Weight     = (k < 24) ? 32'(100 + kbase + k) : 32'hdead_beef;
    end
    @(negedge clk);
    in_valid = 1'b0;
    Img = '0; Kernel_ch1 = '0; Kernel_ch2 = '0; Weight = '0; Opt = 1'b0;
  endtask

  task automatic wait_drain(input int settle);
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (obs_n != 108) begin
      errors++;
      $display("FAIL window_count got %0d required 108", obs_n);
    end
    repeat (settle) @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({win_valid, win_last, win_p0, win_p3, ker1_q, ker2_q, wgt_q, opt_q} !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b opt=%b required all zero", win_valid, opt_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_replication;
    drive_pattern(1'b0, 0, -1, 0, -1);
    wait_drain(3);
    checks++;
    if ({obs_win[0].p0, obs_win[0].p1, obs_win[0].p2, obs_win[0].p3} !== '0) begin
      errors++;
      $display("FAIL rep_000 got %h required 0", obs_win[0]);
    end
    checks++;
    if ({obs_win[35].p0, obs_win[35].p1, obs_win[35].p2, obs_win[35].p3}
        !== {4{32'h41c0_0000}}) begin
      errors++;
      $display("FAIL rep_055 got %h required 4x41c00000", obs_win[35]);
    end
    checks++;
    if ({obs_win[51].p0, obs_win[51].p1, obs_win[51].p2, obs_win[51].p3}
        !== {32'h4200_0000, 32'h4204_0000, 32'h4214_0000, 32'h4218_0000}) begin
      errors++;
      $display("FAIL rep_123 got %h required 42000000 42040000 42140000 42180000",
               obs_win[51]);
    end
  endtask

  task automatic test_zero_pad_contiguous;
    drive_pattern(1'b1, 0, -1, 0, -1);
    wait_drain(3);
    checks++;
    if ({obs_win[0].p0, obs_win[0].p1, obs_win[0].p2, obs_win[0].p3} !== '0) begin
      errors++;
      $display("FAIL zero_000 got %h required 0", obs_win[0]);
    end
    checks++;
    if ({obs_win[107].last, obs_win[107].p0, obs_win[107].p1, obs_win[107].p2,
         obs_win[107].p3} !== {1'b1, 32'h4294_0000, 96'h0}) begin
      errors++;
      $display("FAIL zero_255 got %h required last=1 p0=42940000", obs_win[107]);
    end
    checks++;
    if (obs_cyc[0] != e0 + 1) begin
      errors++;
      $display("FAIL first_window_edge got %0d required %0d", obs_cyc[0], e0 + 1);
    end
    checks++;
    if (obs_cyc[107] != e0 + 108) begin
      errors++;
      $display("FAIL last_window_edge got %0d required %0d", obs_cyc[107], e0 + 108);
    end
  endtask

  task automatic test_gap;
    int need;
    drive_pattern(1'b0, 0, 41, 10, -1);
    wait_drain(3);
    for (int i = 0; i < 108; i++) begin
      need = 25 * (i / 36) + 5 * ((((i % 36) / 6) > 4) ? 4 : (i % 36) / 6)
           + (((i % 6) > 4) ? 4 : i % 6);
      if (need >= 41) begin
        checks++;
        if (obs_cyc[i] < w41_edge + 1) begin
          errors++;
          $display("FAIL gap_stall_%0d got edge %0d required >= %0d", i, obs_cyc[i],
                   w41_edge + 1);
        end
      end
    end
  endtask

  task automatic test_params_back_to_back;
    drive_pattern(1'b1, 0, -1, 0, -1);
    wait_drain(10);
    checks++;
    if ({ker1_q[383:352], ker2_q[31:0], wgt_q[767:736], opt_q}
        !== {32'd11, 32'd200, 32'd123, 1'b1}) begin
      errors++;
      $display("FAIL params_hold got %0d %0d %0d %b required 11 200 123 1",
               ker1_q[383:352], ker2_q[31:0], wgt_q[767:736], opt_q);
    end
    drive_pattern(1'b0, 50, -1, 0, -1);
    wait_drain(0);
    checks++;
    if ({ker1_q[383:352], ker2_q[31:0], wgt_q[767:736], opt_q}
        !== {32'd61, 32'd250, 32'd173, 1'b0}) begin
      errors++;
      $display("FAIL params_overwrite got %0d %0d %0d %b required 61 250 173 0",
               ker1_q[383:352], ker2_q[31:0], wgt_q[767:736], opt_q);
    end
    // Next pattern starts as soon as the block is back in idle.
    drive_pattern(1'b1, 0, -1, 0, -1);
    wait_drain(3);
  endtask

  task automatic test_reset_mid;
    drive_pattern(1'b0, 0, -1, 0, 51);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({win_valid, win_last, win_ch, win_row, win_col, win_p0, win_p1, win_p2, win_p3,
         ker1_q, ker2_q, wgt_q, opt_q} !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b p0=%h required all zero", win_valid, win_p0);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_pattern(1'b0, 0, -1, 0, -1);
    wait_drain(3);
  endtask

  initial begin
    test_reset();
    test_replication();
    test_zero_pad_contiguous();
    test_gap();
    test_params_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
